// File: rtl/regfile_scheduler.sv
// regfile_scheduler
// Issue-side scheduler and write-port arbiter for a 32x32 register file with
// two registered read ports and one write port (x0 hardwired to zero).
// A per-register busy scoreboard holds issue on RAW and WAW hazards, read
// enables are pulsed on issue so operands appear one cycle later alongside
// ex_valid, and ALU/LSU writebacks share the single write port.
module regfile_scheduler #(
  parameter bit LSU_PRIORITY = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  // issue interface
  input  logic        issue_valid,
  output logic        issue_ready,
  input  logic [4:0]  issue_rs1,
  input  logic [4:0]  issue_rs2,
  input  logic [4:0]  issue_rd,
  input  logic        issue_use_rs1,
  input  logic        issue_use_rs2,
  input  logic        issue_writes_rd,
  // register file read ports
  output logic        operand_a_enable,
  output logic        operand_b_enable,
  output logic [4:0]  operand_a_addr,
  output logic [4:0]  operand_b_addr,
  // execute handshake
  output logic        ex_valid,
  input  logic        ex_ready,
  output logic [4:0]  ex_rd,
  // writeback requests
  input  logic        alu_wb_valid,
  output logic        alu_wb_ready,
  input  logic [4:0]  alu_wb_rd,
  input  logic [31:0] alu_wb_data,
  input  logic        lsu_wb_valid,
  output logic        lsu_wb_ready,
  input  logic [4:0]  lsu_wb_rd,
  input  logic [31:0] lsu_wb_data,
  // register file write port
  output logic        result_enable,
  output logic [4:0]  result_addr,
  output logic [31:0] result,
  // scoreboard occupancy
  output logic [5:0]  busy_count
);

  localparam int DATA_W = 32;
  localparam int REG_N  = 32;
  localparam int IDX_W  = 5;
  localparam int CNT_W  = 6;

  // Number of set bits in the scoreboard vector.
  function automatic logic [CNT_W-1:0] popcount(input logic [REG_N-1:0] v);
    logic [CNT_W-1:0] c;
    c = '0;
    for (int i = 0; i < REG_N; i++) begin
      c = c + CNT_W'(v[i]);
    end
    return c;
  endfunction

  // Scoreboard and execute-stage state. Bit 0 of busy is kept at zero so a
  // lookup with index 0 never reports a hazard.
  logic [REG_N-1:0] busy_q, busy_d;
  logic [CNT_W-1:0] busy_count_q, busy_count_d;
  logic             ex_valid_q, ex_valid_d;
  logic [IDX_W-1:0] ex_rd_q, ex_rd_d;

  logic              hazard;
  logic              issue_fire;
  logic              alu_grant;
  logic              lsu_grant;
  logic              wb_grant;
  logic [IDX_W-1:0]  wb_rd;
  logic [DATA_W-1:0] wb_data;

  // Hazard detection and issue handshake. Everything handed out is forced low
  // while reset is asserted so nothing fires against a cleared scoreboard.
  always_comb begin
    hazard = (issue_use_rs1   && busy_q[issue_rs1]) ||
             (issue_use_rs2   && busy_q[issue_rs2]) ||
             (issue_writes_rd && busy_q[issue_rd]);
    issue_ready      = rst_n && !hazard && (!ex_valid_q || ex_ready);
    issue_fire       = issue_valid && issue_ready;
    operand_a_enable = issue_fire && issue_use_rs1;
    operand_b_enable = issue_fire && issue_use_rs2;
    operand_a_addr   = issue_rs1;
    operand_b_addr   = issue_rs2;
  end

  // Write-port arbitration: one grant per cycle, conflicts resolved by
  // LSU_PRIORITY. A grant to x0 completes the handshake without writing.
  always_comb begin
    alu_grant = rst_n && alu_wb_valid && (!lsu_wb_valid || !LSU_PRIORITY);
    lsu_grant = rst_n && lsu_wb_valid && (!alu_wb_valid ||  LSU_PRIORITY);
    wb_grant  = alu_grant || lsu_grant;
    if (lsu_grant) begin
      wb_rd   = lsu_wb_rd;
      wb_data = lsu_wb_data;
    end else begin
      wb_rd   = alu_wb_rd;
      wb_data = alu_wb_data;
    end
    alu_wb_ready  = alu_grant;
    lsu_wb_ready  = lsu_grant;
    result_enable = wb_grant && (wb_rd != '0);
    result_addr   = wb_rd;
    result        = wb_data;
  end

  // Next-state for scoreboard and execute stage. The writeback clear is
  // applied after the issue set so it wins on the same index.
  always_comb begin
    busy_d = busy_q;
    if (issue_fire && issue_writes_rd && (issue_rd != '0)) begin
      busy_d[issue_rd] = 1'b1;
    end
    if (wb_grant) begin
      busy_d[wb_rd] = 1'b0;
    end
    busy_d[0] = 1'b0;
    busy_count_d = popcount(busy_d);

    ex_valid_d = ex_valid_q;
    ex_rd_d    = ex_rd_q;
    if (issue_fire) begin
      ex_valid_d = 1'b1;
      ex_rd_d    = issue_writes_rd ? issue_rd : '0;
    end else if (ex_valid_q && ex_ready) begin
      ex_valid_d = 1'b0;
      ex_rd_d    = '0;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q       <= '0;
      busy_count_q <= '0;
      ex_valid_q   <= 1'b0;
      ex_rd_q      <= '0;
    end else begin
      busy_q       <= busy_d;
      busy_count_q <= busy_count_d;
      ex_valid_q   <= ex_valid_d;
      ex_rd_q      <= ex_rd_d;
    end
  end

  assign ex_valid   = ex_valid_q;
  assign ex_rd      = ex_rd_q;
  assign busy_count = busy_count_q;

endmodule

// File: tb/tb_regfile_scheduler.sv
// Directed testbench for regfile_scheduler with a small register file model
// closing the read/write loop so operand values can be checked end to end.
module tb_regfile_scheduler;

  logic        clk;
  logic        rst_n;
  logic        issue_valid;
  logic        issue_ready;
  logic [4:0]  issue_rs1, issue_rs2, issue_rd;
  logic        issue_use_rs1, issue_use_rs2, issue_writes_rd;
  logic        operand_a_enable, operand_b_enable;
  logic [4:0]  operand_a_addr, operand_b_addr;
  logic        ex_valid;
  logic        ex_ready;
  logic [4:0]  ex_rd;
  logic        alu_wb_valid, lsu_wb_valid;
  logic        alu_wb_ready, lsu_wb_ready;
  logic [4:0]  alu_wb_rd, lsu_wb_rd;
  logic [31:0] alu_wb_data, lsu_wb_data;
  logic        result_enable;
  logic [4:0]  result_addr;
  logic [31:0] result;
  logic [5:0]  busy_count;

  int checks;
  int failures;

  regfile_scheduler #(.LSU_PRIORITY(1'b1)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .issue_valid      (issue_valid),
    .issue_ready      (issue_ready),
    .issue_rs1        (issue_rs1),
    .issue_rs2        (issue_rs2),
    .issue_rd         (issue_rd),
    .issue_use_rs1    (issue_use_rs1),
    .issue_use_rs2    (issue_use_rs2),
    .issue_writes_rd  (issue_writes_rd),
    .operand_a_enable (operand_a_enable),
    .operand_b_enable (operand_b_enable),
    .operand_a_addr   (operand_a_addr),
    .operand_b_addr   (operand_b_addr),
    .ex_valid         (ex_valid),
    .ex_ready         (ex_ready),
    .ex_rd            (ex_rd),
    .alu_wb_valid     (alu_wb_valid),
    .alu_wb_ready     (alu_wb_ready),
    .alu_wb_rd        (alu_wb_rd),
    .alu_wb_data      (alu_wb_data),
    .lsu_wb_valid     (lsu_wb_valid),
    .lsu_wb_ready     (lsu_wb_ready),
    .lsu_wb_rd        (lsu_wb_rd),
    .lsu_wb_data      (lsu_wb_data),
    .result_enable    (result_enable),
    .result_addr      (result_addr),
    .result           (result),
    .busy_count       (busy_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file model: registered reads, one write port, x0 reads as zero.
  logic [31:0] rf_mem [32];
  logic [31:0] rdata_a, rdata_b;
  logic        rf_init;

  always @(posedge clk) begin
    if (rf_init) begin
      for (int i = 0; i < 32; i++) rf_mem[i] <= 32'h1000 + i;
    end else if (result_enable) begin
      rf_mem[result_addr] <= result;
    end
    if (operand_a_enable) rdata_a <= (operand_a_addr == 5'd0) ? 32'h0 : rf_mem[operand_a_addr];
    if (operand_b_enable) rdata_b <= (operand_b_addr == 5'd0) ? 32'h0 : rf_mem[operand_b_addr];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    issue_valid = 1'b0;
    issue_rs1 = '0; issue_rs2 = '0; issue_rd = '0;
    issue_use_rs1 = 1'b0; issue_use_rs2 = 1'b0; issue_writes_rd = 1'b0;
    alu_wb_valid = 1'b0; alu_wb_rd = '0; alu_wb_data = '0;
    lsu_wb_valid = 1'b0; lsu_wb_rd = '0; lsu_wb_data = '0;
  endtask

  task automatic issue(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                       input logic u1, input logic u2, input logic w);
    issue_valid = 1'b1;
    issue_rs1 = rs1; issue_rs2 = rs2; issue_rd = rd;
    issue_use_rs1 = u1; issue_use_rs2 = u2; issue_writes_rd = w;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    checks = 0;
    failures = 0;
    clear_inputs();
    ex_ready = 1'b1;
    rst_n = 1'b0;
    rf_init = 1'b1;
    repeat (3) tick();

    // Requests during reset must not be accepted
    issue(5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 1'b1);
    alu_wb_valid = 1'b1; alu_wb_rd = 5'd4;
    lsu_wb_valid = 1'b1; lsu_wb_rd = 5'd4;
    #1;
    check("rst_issue_ready", 32'(issue_ready), 32'd0);
    check("rst_opa_en", 32'(operand_a_enable), 32'd0);
    check("rst_alu_ready", 32'(alu_wb_ready), 32'd0);
    check("rst_lsu_ready", 32'(lsu_wb_ready), 32'd0);
    check("rst_result_en", 32'(result_enable), 32'd0);
    check("rst_busy_count", 32'(busy_count), 32'd0);
    check("rst_ex_valid", 32'(ex_valid), 32'd0);
    check("rst_ex_rd", 32'(ex_rd), 32'd0);
    clear_inputs();
    rf_init = 1'b0;
    rst_n = 1'b1;
    tick();

    // Basic issue: rs1=1, rs2=2, rd=3
    issue(5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 1'b1);
    #1;
    check("basic_ready", 32'(issue_ready), 32'd1);
    check("basic_opa_en", 32'(operand_a_enable), 32'd1);
    check("basic_opb_en", 32'(operand_b_enable), 32'd1);
    check("basic_opa_addr", 32'(operand_a_addr), 32'd1);
    check("basic_opb_addr", 32'(operand_b_addr), 32'd2);
    tick();
    clear_inputs();
    check("basic_ex_valid", 32'(ex_valid), 32'd1);
    check("basic_ex_rd", 32'(ex_rd), 32'd3);
    check("basic_busy_count", 32'(busy_count), 32'd1);
    check("basic_rdata_a", rdata_a, 32'h1001);
    check("basic_rdata_b", rdata_b, 32'h1002);

    // RAW and WAW on busy x3 hold issue
    issue(5'd3, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
    #1;
    check("raw3_ready", 32'(issue_ready), 32'd0);
    check("raw3_opa_en", 32'(operand_a_enable), 32'd0);
    issue(5'd0, 5'd0, 5'd3, 1'b0, 1'b0, 1'b1);
    #1;
    check("waw3_ready", 32'(issue_ready), 32'd0);
    clear_inputs();
    alu_wb_valid = 1'b1; alu_wb_rd = 5'd3; alu_wb_data = 32'h33;
    #1;
    check("wb3_alu_ready", 32'(alu_wb_ready), 32'd1);
    check("wb3_result_en", 32'(result_enable), 32'd1);
    check("wb3_result_addr", 32'(result_addr), 32'd3);
    check("wb3_result", result, 32'h33);
    tick();
    clear_inputs();
    check("wb3_busy_count", 32'(busy_count), 32'd0);
    check("wb3_ex_valid", 32'(ex_valid), 32'd0);

    // RAW through writeback: rd=5 then rs1=5 waits for ALU write
    issue(5'd0, 5'd0, 5'd5, 1'b0, 1'b0, 1'b1);
    tick();
    clear_inputs();
    check("raw_busy1", 32'(busy_count), 32'd1);
    issue(5'd5, 5'd0, 5'd6, 1'b1, 1'b0, 1'b1);
    #1;
    check("raw_stall_a", 32'(issue_ready), 32'd0);
    tick();
    check("raw_stall_b", 32'(issue_ready), 32'd0);
    alu_wb_valid = 1'b1; alu_wb_rd = 5'd5; alu_wb_data = 32'hDEADBEEF;
    #1;
    check("raw_stall_wb_cycle", 32'(issue_ready), 32'd0);
    check("raw_wb_ready", 32'(alu_wb_ready), 32'd1);
    tick();
    alu_wb_valid = 1'b0;
    #1;
    check("raw_issue_ready", 32'(issue_ready), 32'd1);
    check("raw_opa_en", 32'(operand_a_enable), 32'd1);
    check("raw_opa_addr", 32'(operand_a_addr), 32'd5);
    tick();
    clear_inputs();
    check("raw_rdata_a", rdata_a, 32'hDEADBEEF);
    check("raw_ex_rd", 32'(ex_rd), 32'd6);
    check("raw_busy_after", 32'(busy_count), 32'd1);
    lsu_wb_valid = 1'b1; lsu_wb_rd = 5'd6; lsu_wb_data = 32'h66;
    tick();
    clear_inputs();
    check("raw_drain", 32'(busy_count), 32'd0);

    // Back-to-back issue then write-port conflict
    issue(5'd0, 5'd0, 5'd7, 1'b0, 1'b0, 1'b1);
    tick();
    issue(5'd0, 5'd0, 5'd8, 1'b0, 1'b0, 1'b1);
    #1;
    check("b2b_ready", 32'(issue_ready), 32'd1);
    tick();
    clear_inputs();
    check("conf_busy2", 32'(busy_count), 32'd2);
    check("conf_ex_rd", 32'(ex_rd), 32'd8);
    lsu_wb_valid = 1'b1; lsu_wb_rd = 5'd7; lsu_wb_data = 32'h11;
    alu_wb_valid = 1'b1; alu_wb_rd = 5'd8; alu_wb_data = 32'h22;
    #1;
    check("conf_lsu_ready", 32'(lsu_wb_ready), 32'd1);
    check("conf_alu_ready", 32'(alu_wb_ready), 32'd0);
    check("conf_addr_lsu", 32'(result_addr), 32'd7);
    check("conf_data_lsu", result, 32'h11);
    tick();
    check("conf_busy1", 32'(busy_count), 32'd1);
    lsu_wb_valid = 1'b0;
    #1;
    check("conf_alu_ready2", 32'(alu_wb_ready), 32'd1);
    check("conf_addr_alu", 32'(result_addr), 32'd8);
    check("conf_data_alu", result, 32'h22);
    tick();
    clear_inputs();
    check("conf_busy0", 32'(busy_count), 32'd0);
    issue(5'd7, 5'd8, 5'd0, 1'b1, 1'b1, 1'b0);
    tick();
    clear_inputs();
    check("conf_read7", rdata_a, 32'h11);
    check("conf_read8", rdata_b, 32'h22);

    // x0 destination never goes busy and is never written
    issue(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
    tick();
    clear_inputs();
    check("x0_busy", 32'(busy_count), 32'd0);
    check("x0_ex_rd", 32'(ex_rd), 32'd0);
    check("x0_ex_valid", 32'(ex_valid), 32'd1);
    lsu_wb_valid = 1'b1; lsu_wb_rd = 5'd0; lsu_wb_data = 32'hFFFFFFFF;
    #1;
    check("x0_lsu_ready", 32'(lsu_wb_ready), 32'd1);
    check("x0_result_en", 32'(result_enable), 32'd0);
    tick();
    clear_inputs();
    check("x0_busy_after", 32'(busy_count), 32'd0);
    issue(5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
    tick();
    clear_inputs();
    check("x0_read", rdata_a, 32'h0);
    tick();

    // Backpressure from execute
    ex_ready = 1'b0;
    issue(5'd1, 5'd2, 5'd0, 1'b1, 1'b1, 1'b0);
    #1;
    check("bp_first_ready", 32'(issue_ready), 32'd1);
    tick();
    issue(5'd9, 5'd10, 5'd0, 1'b1, 1'b1, 1'b0);
    #1;
    check("bp_ready_low", 32'(issue_ready), 32'd0);
    check("bp_opa_en", 32'(operand_a_enable), 32'd0);
    check("bp_opb_en", 32'(operand_b_enable), 32'd0);
    check("bp_ex_valid", 32'(ex_valid), 32'd1);
    tick();
    check("bp_held_a", rdata_a, 32'h1001);
    check("bp_held_b", rdata_b, 32'h1002);
    check("bp_ex_valid_held", 32'(ex_valid), 32'd1);
    ex_ready = 1'b1;
    #1;
    check("bp_release_ready", 32'(issue_ready), 32'd1);
    check("bp_release_opa_en", 32'(operand_a_enable), 32'd1);
    tick();
    clear_inputs();
    check("bp_new_a", rdata_a, 32'h1009);
    check("bp_new_b", rdata_b, 32'h100A);
    check("bp_new_ex_valid", 32'(ex_valid), 32'd1);

    // Asynchronous reset with three registers busy
    issue(5'd0, 5'd0, 5'd11, 1'b0, 1'b0, 1'b1);
    tick();
    issue(5'd0, 5'd0, 5'd12, 1'b0, 1'b0, 1'b1);
    tick();
    issue(5'd0, 5'd0, 5'd13, 1'b0, 1'b0, 1'b1);
    tick();
    clear_inputs();
    check("ar_busy3", 32'(busy_count), 32'd3);
    check("ar_ex_valid_pre", 32'(ex_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_busy0", 32'(busy_count), 32'd0);
    check("ar_ex_valid", 32'(ex_valid), 32'd0);
    check("ar_ex_rd", 32'(ex_rd), 32'd0);
    check("ar_issue_ready", 32'(issue_ready), 32'd0);
    tick();
    rst_n = 1'b1;
    #1;
    alu_wb_valid = 1'b1; alu_wb_rd = 5'd11; alu_wb_data = 32'hBB;
    #1;
    check("ar_late_wb_ready", 32'(alu_wb_ready), 32'd1);
    check("ar_late_wb_en", 32'(result_enable), 32'd1);
    tick();
    clear_inputs();
    check("ar_late_busy", 32'(busy_count), 32'd0);
    issue(5'd11, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
    tick();
    clear_inputs();
    check("ar_late_read", rdata_a, 32'hBB);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/regfile_scheduler.md
# regfile_scheduler

Issue-side scheduler and write-port arbiter for the 32x32 register file: two registered read ports, one write port, register 0 hardwired to zero. It tracks a per-register busy scoreboard and holds issue while a source or destination register has a write pending. It drives the read enables and addresses, presents operand-valid to execute aligned with the file's one-cycle read latency, and arbitrates ALU and LSU writebacks onto the single write port.

## Interface
- LSU_PRIORITY, default 1: 1 = LSU wins write-port conflicts; 0 = ALU wins.
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- issue_valid  in  1  instruction presented for issue
- issue_ready  out  1  issue accepted this cycle when both high
- issue_rs1, issue_rs2, issue_rd  in  5 each  source and destination register indices
- issue_use_rs1, issue_use_rs2, issue_writes_rd  in  1 each  qualify the three indices
- operand_a_enable, operand_b_enable  out  1 each  register file read enables
- operand_a_addr, operand_b_addr  out  5 each  register file read addresses
- ex_valid  out  1  operands on the register file outputs are valid for execute
- ex_ready  in  1  execute consumes the operands
- ex_rd  out  5  destination of the instruction in execute, 0 if none
- alu_wb_valid, lsu_wb_valid  in  1 each  writeback request
- alu_wb_ready, lsu_wb_ready  out  1 each  writeback granted, combinational
- alu_wb_rd, lsu_wb_rd  in  5 each  writeback register
- alu_wb_data, lsu_wb_data  in  32 each  writeback data
- result_enable  out  1  register file write enable
- result_addr  out  5  register file write address
- result  out  32  register file write data
- busy_count  out  6  number of registers currently marked busy

## Operation
- Scoreboard: busy[31:1] register. busy[0] reads as 0 and is never set.
- Hazard: (issue_use_rs1 && busy[rs1]) || (issue_use_rs2 && busy[rs2]) || (issue_writes_rd && busy[rd]). WAW stalls as well as RAW.
- issue_ready = !hazard && (!ex_valid || ex_ready). issue_ready is combinational and does not depend on issue_valid.
- On issue fire (issue_valid && issue_ready):
  - operand_a_enable = issue_use_rs1 and operand_b_enable = issue_use_rs2, for this cycle only.
  - operand_a_addr and operand_b_addr follow issue_rs1 and issue_rs2 combinationally.
  - ex_valid is set on the next edge.
  - ex_rd takes rd when writes_rd, else 0.
  - busy[rd] is set if writes_rd and rd != 0.
- Read enables stay low when not firing. The file holds its outputs, so stalled operands stay stable.
- ex_valid clears on ex_valid && ex_ready with no new fire. Fire and consume in the same cycle keeps ex_valid at 1.
- Write-port arbitration:
  - Only one writeback source is granted per cycle.
  - With both valid, the LSU_PRIORITY winner is granted and the loser's ready is 0.
  - Grant drives result_enable = (wb_rd != 0), result_addr, and result combinationally from the winner.
  - A grant to rd 0 completes the handshake with no write.
- Granted writeback clears busy[wb_rd] on the edge.
- A clear and a set of the same index in one cycle cannot occur, because WAW stalls issue. The clear takes precedence.
- busy_count is the registered popcount of busy, updated with busy.

## Timing
- Reset (rst_n low, asynchronous): busy = 0, ex_valid = 0, ex_rd = 0, busy_count = 0.
- During reset, all enables and readies are low, including issue_ready and the wb readies.
- Read latency: fire in cycle N means operands are valid and ex_valid = 1 in cycle N+1.
- Write-to-read: a writeback granted in cycle N clears busy at the N edge, so a dependent instruction issues in N+1 at the earliest. No same-cycle bypass is allowed, because the file would return the old value.
- Back-to-back issue of independent instructions every cycle is supported when ex_ready = 1.
- Deasserting rst_n mid-operation discards in-flight state. Writebacks arriving after reset for no-longer-busy registers are still written; the scoreboard stays at 0.

## Test plan
- Reset, then issue rs1=1, rs2=2, rd=3 with ex_ready=1 -> enables high in cycle 0, ex_valid=1 and ex_rd=3 in cycle 1, busy_count=1.
- RAW: issue rd=5, then an instruction with rs1=5. The ALU writes 5 <- 0xDEADBEEF in cycle 4 -> issue_ready=0 through cycle 4; dependent issues in cycle 5, and operand_a=0xDEADBEEF in cycle 6.
- Conflict: ALU and LSU both valid in one cycle, LSU rd=7 (0x11), ALU rd=8 (0x22), LSU_PRIORITY=1 -> LSU written first with alu_wb_ready=0; ALU written the next cycle; busy_count falls 2 -> 1 -> 0.
- x0: issue with rd=0, then writeback rd=0 with data 0xFFFFFFFF -> busy_count stays 0, lsu_wb_ready=1, result_enable=0, and a later read of x0 returns 0.
- Backpressure: ex_ready=0 while ex_valid=1 -> issue_ready=0, read enables stay low, and operands are held. ex_ready=1 -> new issue fires the same cycle.
- Async reset with 3 registers busy and ex_valid=1 -> busy_count=0 and ex_valid=0 immediately, without waiting for a clock edge.
